// File: rtl/spigot_uart_tx.sv
// spigot_uart_tx: digit FIFO, '.'/CR/LF sequencer and UART serialiser.
// Framing is 8N1 by default; define SPIGOT_UART_PARITY_EN for 8E1.
module spigot_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned LINE_LEN     = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic       digit_ready,
  output logic       tx,
  output logic       busy
);

`ifdef SPIGOT_UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;
`endif

  localparam logic [15:0] BAUD_LD   = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  LINE_LAST = 8'(LINE_LEN - 1);

  logic [3:0]  mem_q [4];
  logic [1:0]  wr_q;
  logic [1:0]  rd_q;
  logic [2:0]  cnt_q;
  logic        push;
  logic        pop;

  logic        first_q;
  logic        dot_q;
  logic        cr_q;
  logic        lf_q;
  logic [7:0]  dcnt_q;

  state_e      state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic        tx_q;
`ifdef SPIGOT_UART_PARITY_EN
  logic        par_q;
`endif

  logic        avail;
  logic        take;
  logic        end_bit;
  logic        is_dig;
  logic [7:0]  ch;
  logic [3:0]  head;

  assign head        = mem_q[rd_q];
  assign digit_ready = (cnt_q != 3'd4);
  assign push        = digit_valid && digit_ready;
  assign end_bit     = (baud_q == 16'd0);
  assign avail       = dot_q || cr_q || lf_q || (cnt_q != 3'd0);
  assign take        = avail &&
                       ((state_q == S_IDLE) ||
                        ((state_q == S_STOP) && end_bit));
  assign pop         = take && is_dig;
  assign tx          = tx_q;
  // Built only from registers, so it moves only on edges or reset.
  assign busy        = (state_q != S_IDLE) || avail;

  // Pick the next character: inserted '.', CR, LF beat FIFO digits.
  always_comb begin
    ch     = 8'h2E;
    is_dig = 1'b0;
    priority case (1'b1)
      dot_q: ch = 8'h2E;
      cr_q:  ch = 8'h0D;
      lf_q:  ch = 8'h0A;
      default: begin
        ch     = (head <= 4'd9) ? {4'h3, head} : 8'h3F;
        is_dig = (cnt_q != 3'd0);
      end
    endcase
  end

  // Four-entry digit FIFO; a full FIFO refuses pushes even when popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 4'd0;
      end
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= digit;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) begin
        rd_q <= rd_q + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Track decimal point and line breaks as characters are taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      dot_q   <= 1'b0;
      cr_q    <= 1'b0;
      lf_q    <= 1'b0;
      dcnt_q  <= 8'd0;
    end else if (take) begin
      priority case (1'b1)
        dot_q: dot_q <= 1'b0;
        cr_q: begin
          cr_q <= 1'b0;
          lf_q <= 1'b1;
        end
        lf_q: lf_q <= 1'b0;
        default: begin
          if (first_q) begin
            first_q <= 1'b0;
            dot_q   <= 1'b1;
          end
          if (dcnt_q == LINE_LAST) begin
            dcnt_q <= 8'd0;
            cr_q   <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  // Serialiser FSM; every state lasts one bit time of the baud counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      tx_q    <= 1'b1;
`ifdef SPIGOT_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (take) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
            baud_q  <= BAUD_LD;
            sh_q    <= ch;
`ifdef SPIGOT_UART_PARITY_EN
            par_q   <= ^ch;
`endif
          end
        end
        S_START: begin
          if (end_bit) begin
            state_q <= S_DATA;
            tx_q    <= sh_q[0];
            bit_q   <= 3'd0;
            baud_q  <= BAUD_LD;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        S_DATA: begin
          if (end_bit) begin
            baud_q <= BAUD_LD;
            if (bit_q == 3'd7) begin
`ifdef SPIGOT_UART_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              sh_q  <= {1'b0, sh_q[7:1]};
              tx_q  <= sh_q[1];
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
`ifdef SPIGOT_UART_PARITY_EN
        S_PARITY: begin
          if (end_bit) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
            baud_q  <= BAUD_LD;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (end_bit) begin
            if (take) begin
              state_q <= S_START;
              tx_q    <= 1'b0;
              baud_q  <= BAUD_LD;
              sh_q    <= ch;
`ifdef SPIGOT_UART_PARITY_EN
              par_q   <= ^ch;
`endif
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spigot_uart_tx.sv
// tb_spigot_uart_tx: scoreboard bench for spigot_uart_tx.
// A UART monitor decodes tx frames and checks them against a queue.
module tb_spigot_uart_tx;
  localparam int CPB = 4;
  localparam int LL  = 3;
`ifdef SPIGOT_UART_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FR  = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_ready;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  bit mon_en = 1'b1;
  logic [7:0] exp_q[$];
  int start_q[$];

  spigot_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .LINE_LEN(LL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digit_valid(digit_valid),
    .digit(digit),
    .digit_ready(digit_ready),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: decode each frame mid-bit and score it.
  initial begin : monitor
    logic [7:0] b;
    int s;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        s = cyc;
        b = 8'h00;
        repeat (CPB + CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx;
          if (i < 7) repeat (CPB) @(negedge clk);
        end
`ifdef SPIGOT_UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        chk("parity_bit", {31'd0, tx}, {31'd0, ^b});
`endif
        repeat (CPB) @(negedge clk);
        chk("stop_bit", {31'd0, tx}, 32'd1);
        start_q.push_back(s);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", b);
        end else begin
          chk("byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_q.delete();
  endtask

  task automatic push(input logic [3:0] d);
    int n;
    n = 0;
    digit_valid = 1'b1;
    digit = d;
    while (!digit_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(nm, {31'd0, n < 3000}, 32'd1);
  endtask

  initial begin : stim
    int idx;
    bit acc;
    logic [7:0] seq1 [7];
    seq1 = '{8'h33, 8'h2E, 8'h31, 8'h34, 8'h0D, 8'h0A, 8'h31};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, digit_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single digit 3: timing of '3' and '.' frames
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h2E);
    push(4'd3);
    c0 = cyc;
    while (cyc < c0 + 2 * FR) @(negedge clk);
    chk("busy_in_stop", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_after", {31'd0, busy}, 32'd0);
    drain("drain_d3");
    chk("d3_start", start_q[0] - c0, 32'd1);
    chk("dot_start", start_q[1] - c0, 32'(1 + FR));

    // Hold valid high: five accepted, then backpressure
    do_reset();
    exp_q = '{8'h31, 8'h2E, 8'h32, 8'h33, 8'h0D, 8'h0A,
              8'h34, 8'h35};
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      digit_valid = (idx < 6);
      digit = 4'(idx + 1);
      acc = digit_valid && digit_ready;
      @(posedge clk);
      #1;
      if (k == 0) c0 = cyc;
      if (acc) idx++;
      @(negedge clk);
    end
    digit_valid = 1'b0;
    chk("accepted", idx, 32'd5);
    chk("ready_full", {31'd0, digit_ready}, 32'd0);
    while (cyc < c0 + 2 * FR) @(negedge clk);
    chk("ready_before_pop", {31'd0, digit_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_pop", {31'd0, digit_ready}, 32'd1);
    drain("drain_full");

    // 3,1,4,1 with line break, back-to-back frames
    do_reset();
    for (int i = 0; i < 7; i++) exp_q.push_back(seq1[i]);
    push(4'd3);
    c0 = cyc;
    push(4'd1);
    push(4'd4);
    push(4'd1);
    drain("drain_3141");
    chk("3141_first", start_q[0] - c0, 32'd1);
    for (int i = 0; i + 1 < start_q.size(); i++) begin
      chk("b2b_gap", start_q[i + 1] - start_q[i], 32'(FR));
    end
    chk("3141_frames", start_q.size(), 32'd7);

    // Non-BCD digit maps to '?'
    do_reset();
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h2E);
    push(4'd12);
    drain("drain_q");

    // Reset mid-frame aborts the frame
    do_reset();
    mon_en = 1'b0;
    push(4'd5);
    c0 = cyc;
    while (cyc < c0 + 15) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, digit_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    start_q.delete();
    repeat (60) @(negedge clk);
    chk("no_resume", start_q.size(), 32'd0);
    exp_q.push_back(8'h37);
    exp_q.push_back(8'h2E);
    push(4'd7);
    drain("drain_rst");
    chk("rst_frames", start_q.size(), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spigot_uart_tx.md
SPIGOT_UART_TX -- requirements
Module: spigot_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter LINE_LEN, default 50, digits per output line before a CR/LF pair (legal range 1..255).
REQ-003 SHALL have port clk, input, 1, single clock; all logic clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port digit_valid, input, 1, upstream spigot core offers a digit.
REQ-006 SHALL have port digit, input, 4, offered digit value (BCD).
REQ-007 SHALL have port digit_ready, output, 1, block can accept a digit this cycle.
REQ-008 SHALL have port tx, output, 1, UART serial line; idle high.
REQ-009 SHALL have port busy, output, 1, high while a frame is on the line or the FIFO is non-empty.

Function
REQ-010 SHALL accept a digit on a rising edge where digit_valid and digit_ready are both high.
REQ-011 SHALL buffer accepted digits in a 4-entry FIFO; digit_ready = (FIFO count < 4), from current state only.
REQ-012 When the FIFO is full, a pop and a push offered in the same cycle SHALL NOT accept the push.
REQ-013 SHALL map digit 0..9 to ASCII 0x30..0x39; digit 10..15 to 0x3F ('?').
REQ-014 After the first digit since reset, SHALL insert 0x2E ('.') as the next character without popping the FIFO.
REQ-015 SHALL count transmitted digits (excluding '.'); on reaching LINE_LEN, SHALL send 0x0D then 0x0A, then clear the count.
REQ-016 Character sequencer SHALL have priority: pending '.' > pending CR > pending LF > FIFO pop.
REQ-017 SHALL implement TX FSM states IDLE, START, DATA, PARITY, STOP; PARITY exists only per REQ-026.
REQ-018 IDLE -> START on the edge a character is available; tx goes low on that edge; FIFO pops on that edge.
REQ-019 Each state SHALL last exactly CLKS_PER_BIT cycles via a down-counter reloaded at each bit boundary.
REQ-020 DATA SHALL send 8 bits LSB first; STOP sends one high bit, then IDLE, or directly START if a character is available.
REQ-021 Latency: digit accepted at edge N into an empty, idle block drives tx low from edge N+1.
REQ-022 busy and digit_ready SHALL change only on clock edges or reset.

Reset
REQ-023 While rst_n low: tx=1, busy=0, FIFO count=0, digit_ready=1, FSM=IDLE, digit count=0, first-digit flag set.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously); no partial frame resumes.
REQ-025 First digit after reset release SHALL again be followed by '.'.

Configuration
REQ-026 Macro SPIGOT_UART_PARITY_EN defined: SHALL insert an even-parity bit (XOR of 8 data bits) between DATA and STOP, 11 bit-times per frame. Undefined: 8N1, 10 bit-times per frame, no PARITY state.

Verification (CLKS_PER_BIT=4, LINE_LEN=3, macro undefined unless stated)
REQ-027 Push digit 3 at edge 0 -> tx low edges 1..4, data 1,1,0,0,1,1,0,0, stop; then 0x2E frame starts at edge 41; busy low after it.
REQ-028 Hold digit_valid high with tx busy, 6 digits queued -> exactly 5 accepted (1 popped at edge 1, 4 buffered), then digit_ready low until first FIFO pop.
REQ-029 Push 3,1,4,1 -> line bytes 0x33,0x2E,0x31,0x34,0x0D,0x0A,0x31, back-to-back frames.
REQ-030 Push digit 12 -> frame byte 0x3F.
REQ-031 Assert rst_n low at edge 15 of a frame -> tx=1 immediately, busy=0; after release, push 7 -> 0x37 then 0x2E.
REQ-032 With SPIGOT_UART_PARITY_EN, push 3 -> 0x33 frame with parity bit 0, 44 cycles per frame.
